// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the EX-stage divide sequencer: control codes and FSM encodings.
package div_sequencer_pkg;

    // EX-stage ALU control codes that map onto start / signed_div.
    localparam logic [5:0] DIV_CONTROL  = 6'b011010;
    localparam logic [5:0] DIVU_CONTROL = 6'b011011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Request/result bundle between the EX stage (master) and the divide sequencer (slave).
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, signed_div, a, b, flush,
        input  stall, done, hi_out, lo_out
    );

    modport slave (
        input  start, signed_div, a, b, flush,
        output stall, done, hi_out, lo_out
    );
endinterface

// File: rtl/div_sequencer_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The bit shifted out of rem must take part in the compare, hence WIDTH+1 bits.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs};
    assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage (restoring, WIDTH iterations).
// Optional DIV_ZERO_SKIP_EN: divide-by-zero skips the iteration and finishes from PREP.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           resetn,
    div_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e           state, state_next;
    logic             stall_c;
    logic             accept;
    logic             last_iter;
    logic             b_zero;
    logic             signed_q, qneg, rneg;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] dvs, rem, quo;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign accept    = bus.start & ~bus.flush;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign b_zero    = (b_q == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .dvs      (dvs),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_next = state;
        stall_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                stall_c = accept;
                if (accept) state_next = ST_PREP;
            end
            ST_PREP: begin
                stall_c = 1'b1;
`ifdef DIV_ZERO_SKIP_EN
                state_next = b_zero ? ST_DONE : ST_RUN;
`else
                state_next = ST_RUN;
`endif
            end
            ST_RUN: begin
                stall_c = 1'b1;
                if (last_iter) state_next = ST_FIX;
            end
            ST_FIX: begin
                stall_c    = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (bus.flush) state_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            signed_q <= 1'b0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    signed_q <= bus.signed_div;
                    a_q      <= bus.a;
                    b_q      <= bus.b;
                    qneg     <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    rneg     <= bus.signed_div & bus.a[WIDTH-1];
                end
                ST_PREP: begin
                    quo <= magnitude(a_q, signed_q & a_q[WIDTH-1]);
                    dvs <= magnitude(b_q, signed_q & b_q[WIDTH-1]);
                    rem <= '0;
                    cnt <= '0;
`ifdef DIV_ZERO_SKIP_EN
                    if (b_zero && !bus.flush) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                    end
`endif
                end
                ST_RUN: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + 1'b1;
                end
                ST_FIX: if (!bus.flush) begin
                    // Divide-by-zero reports the raw dividend, bypassing sign correction.
                    if (b_zero) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rneg ? -rem : rem;
                        lo_q <= qneg ? -quo : quo;
                    end
                end
                default: ;
            endcase
            done_q <= (state_next == ST_DONE);
        end
    end

    assign bus.stall  = stall_c;
    assign bus.done   = done_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed vector table, corner sequences, random vs model.
module tb_div_sequencer;
    localparam int WIDTH    = 32;
    localparam int LAT_FULL = WIDTH + 3;
`ifdef DIV_ZERO_SKIP_EN
    localparam int LAT_ZERO = 2;
`else
    localparam int LAT_ZERO = WIDTH + 3;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    div_sequencer_if #(.WIDTH(WIDTH)) bus();

    div_sequencer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with truncation toward zero.
    function automatic void model(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (bv == 0) begin
            q = '1;
            r = av;
        end else if (!sd) begin
            q = av / bv;
            r = av % bv;
        end else begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
    endfunction

    // Entered and left at 1 time unit after a rising edge; the call cycle is cycle 0.
    task automatic run_op(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi, input string tag);
        int   n;
        int   lat;
        logic stall_ok;
        lat            = (bv == 0) ? LAT_ZERO : LAT_FULL;
        bus.start      = 1'b1;
        bus.signed_div = sd;
        bus.a          = av;
        bus.b          = bv;
        #1 check({tag, " stall_c0"}, 64'(bus.stall), 64'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        n         = 1;
        stall_ok  = 1'b1;
        while (!bus.done && n < 100) begin
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " stall_busy"}, 64'(stall_ok), 64'd1);
        check({tag, " stall_done"}, 64'(bus.stall), 64'd0);
        check({tag, " lo"}, 64'(bus.lo_out), 64'(exp_lo));
        check({tag, " hi"}, 64'(bus.hi_out), 64'(exp_hi));
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
        last_lo = exp_lo;
        last_hi = exp_hi;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[12];
        logic        sd, any_done;
        logic [31:0] av, bv, q, r, got_lo, got_hi;
        int          dones, done_cyc;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h0};
        vecs[3]  = '{1'b0, 32'd5,          32'd0,        32'hFFFFFFFF, 32'd5};
        vecs[4]  = '{1'b1, 32'hFFFFFFF8,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFF8};
        vecs[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
        vecs[6]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0};
        vecs[8]  = '{1'b0, 32'd3,          32'd10,       32'd0,        32'd3};
        vecs[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000};
        vecs[10] = '{1'b1, 32'h80000000,   32'd1,        32'h80000000, 32'd0};
        vecs[11] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        32'd0};

        resetn         = 1'b0;
        bus.start      = 1'b0;
        bus.flush      = 1'b0;
        bus.signed_div = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset hi", 64'(bus.hi_out), 64'd0);
        check("reset lo", 64'(bus.lo_out), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset stall", 64'(bus.stall), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, $sformatf("vec%0d", i));

        // start together with flush in IDLE: nothing accepted.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.a     = 32'd50;
        bus.b     = 32'd5;
        #1 check("start_flush stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start_flush idle", 64'(bus.stall), 64'd0);
        any_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) any_done = 1'b1;
            @(posedge clk); #1;
        end
        check("start_flush no_done", 64'(any_done), 64'd0);

        // Flush in cycle 10, restart in cycle 12.
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.a          = 32'd12345;
        bus.b          = 32'd67;
        @(posedge clk); #1;
        bus.start = 1'b0;
        any_done  = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (bus.done) any_done = 1'b1;
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush stall_c11", 64'(bus.stall), 64'd0);
        check("flush no_done", 64'(any_done | bus.done), 64'd0);
        check("flush hi_hold", 64'(bus.hi_out), 64'(last_hi));
        check("flush lo_hold", 64'(bus.lo_out), 64'(last_lo));
        @(posedge clk); #1;
        run_op(1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, "restart");

        // start pulsed during RUN is ignored.
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.a          = 32'd1000;
        bus.b          = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones     = 0;
        done_cyc  = -1;
        got_lo    = '0;
        got_hi    = '0;
        for (int c = 1; c < 80; c++) begin
            bus.start = (c == 10);
            if (c == 10) begin
                bus.signed_div = 1'b1;
                bus.a          = 32'hFFFFFF00;
                bus.b          = 32'd7;
            end
            if (bus.done) begin
                dones++;
                done_cyc = c;
                got_lo   = bus.lo_out;
                got_hi   = bus.hi_out;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("ignore done_count", 64'(dones), 64'd1);
        check("ignore done_cycle", 64'(done_cyc), 64'(LAT_FULL));
        check("ignore lo", 64'(got_lo), 64'd333);
        check("ignore hi", 64'(got_hi), 64'd1);
        last_lo = 32'd333;
        last_hi = 32'd1;

        for (int i = 0; i < 40; i++) begin
            sd = 1'($urandom);
            av = $urandom;
            bv = $urandom;
            case ($urandom_range(0, 7))
                0: bv = '0;
                1: bv = $urandom_range(1, 15);
                2: bv = '1;
                3: av = 32'h80000000;
                4: av = $urandom_range(0, 255);
                default: ;
            endcase
            model(sd, av, bv, q, r);
            run_op(sd, av, bv, q, r, $sformatf("rand%0d", i));
        end

        // Reset asserted in cycle 20 of an operation.
        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "pre_reset");
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.a          = 32'd99;
        bus.b          = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        #1;
        check("midreset hi", 64'(bus.hi_out), 64'd0);
        check("midreset lo", 64'(bus.lo_out), 64'd0);
        check("midreset done", 64'(bus.done), 64'd0);
        check("midreset stall", 64'(bus.stall), 64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        any_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) any_done = 1'b1;
            @(posedge clk); #1;
        end
        check("midreset no_done", 64'(any_done), 64'd0);
        last_lo = '0;
        last_hi = '0;
        run_op(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
